// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: state, owner and transfer-length encodings shared by the RAM port arbiter.
package mem_arbiter_pkg;
    typedef enum logic [1:0] {MEM_IDLE, MEM_BUSY, MEM_DONE} state_t;
    typedef enum logic {OWN_IF, OWN_MEM} owner_t;
    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        return len == LEN_BYTE ? 3'd1 : len == LEN_HALF ? 3'd2 : 3'd4;
    endfunction
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide RAM port between IF and MEM, running byte-serial
// 1/2/4-byte little-endian transfers with MEM at fixed priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_data,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_len,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr
);
    state_t      state;
    owner_t      owner;
    logic [2:0]  cnt, n;
    logic        we, xfer;
    logic [31:0] base, wbuf, rbuf, rnext;
    logic [1:0]  ri, wi;
    always_comb begin
        xfer      = state == MEM_BUSY && cnt < n;
        wi        = cnt[1:0];
        ri        = 2'(cnt - 3'd1);
        rnext     = rbuf;
        rnext[{ri, 3'b000} +: 8] = ram_din;
        ram_a     = xfer ? base + {29'b0, cnt} : '0;
        ram_wr    = rdy && xfer && we;
        ram_dout  = ram_wr ? wbuf[{wi, 3'b000} +: 8] : '0;
        if_ready  = rdy && state == MEM_DONE && owner == OWN_IF;
        mem_ready = rdy && state == MEM_DONE && owner == OWN_MEM;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MEM_IDLE;
            owner     <= OWN_IF;
            cnt       <= '0;
            n         <= '0;
            we        <= 1'b0;
            base      <= '0;
            wbuf      <= '0;
            rbuf      <= '0;
            if_data   <= '0;
            mem_rdata <= '0;
        end else if (rdy) begin
            case (state)
                MEM_IDLE: begin
                    cnt  <= '0;
                    rbuf <= '0;
                    if (mem_req) begin
                        state <= MEM_BUSY;
                        owner <= OWN_MEM;
                        we    <= mem_we;
                        n     <= len_bytes(mem_len);
                        base  <= mem_addr;
                        wbuf  <= mem_wdata;
                    end else if (if_req) begin
                        state <= MEM_BUSY;
                        owner <= OWN_IF;
                        we    <= 1'b0;
                        n     <= 3'd4;
                        base  <= if_addr;
                        wbuf  <= '0;
                    end
                end
                MEM_BUSY: begin
                    // A dropped if_req mid-fetch is a branch flush: discard silently.
                    if (owner == OWN_IF && !if_req) begin
                        state <= MEM_IDLE;
                    end else if (we) begin
                        cnt <= cnt + 3'd1;
                        if (cnt == n - 3'd1) state <= MEM_DONE;
                    end else begin
                        cnt <= cnt + 3'd1;
                        if (cnt != 3'd0) rbuf <= rnext;
                        if (cnt == n) begin
                            state <= MEM_DONE;
                            if (owner == OWN_IF) if_data <= rnext;
                            else mem_rdata <= rnext;
                        end
                    end
                end
                default: state <= MEM_IDLE;
            endcase
        end
    end
endmodule
